fetchbuffer: RTL and testbench
==============================

# fetchbuffer

Instruction prefetch buffer between the fetch stage and instruction memory. It accepts halfword-aligned fetch requests on a `mem_in_type` port and returns a complete 16- or 32-bit instruction with a same-cycle `mem_ready`. It issues word-aligned 32-bit reads to instruction memory, one outstanding at a time, and stores the returned halfwords in a circular buffer. Compressed and misaligned 32-bit instructions are therefore served without stalling the fetch stage on every access.

## Interface
- `fetchbuffer_depth` (default 8): buffer capacity in halfwords; must be a power of two and at least 4. Lives in package `constants`.
- Reset and clock: reset `rst`, synchronous, active-low; clock `clk`.
- `rst`  in  1  synchronous reset, active-low.
- `clk`  in  1  clock, rising edge.
- `fetchbuffer_in`  in  `mem_in_type`  request from the fetch stage.
  - Uses `mem_valid`, `mem_fence`, `mem_addr`.
  - `mem_instr`, `mem_wdata` and `mem_wstrb` are ignored.
- `fetchbuffer_out`  out  `mem_out_type`  instruction response: `mem_ready`, `mem_rdata[31:0]`.
- `imem_out`  in  `mem_out_type`  memory response: `mem_ready` is a 1-cycle pulse, `mem_rdata` is the word.
- `imem_in`  out  `mem_in_type`  memory request.
  - `mem_valid`, `mem_addr` (word-aligned), `mem_fence`.
  - `mem_instr` = 1, `mem_wdata` = 0, `mem_wstrb` = 0.

## Operation
- State: halfword array `buf[depth]`, read pointer `rptr`, write pointer `wptr`, `count` (0..depth), head address `haddr`, fetch address `faddr` (word-aligned), `pend`, `drop`, `skip`.
- Hit condition: `mem_valid` is 1, `mem_addr` equals `haddr`, and either:
  - `count` ≥ 1 and `buf[rptr][1:0]` ≠ 2'b11, or
  - `count` ≥ 2.
- On a hit:
  - `mem_ready` = 1.
  - `mem_rdata` = {`buf[rptr+1]`, `buf[rptr]`} for a 32-bit instruction.
  - `mem_rdata` = {16'h0, `buf[rptr]`} for a compressed instruction.
  - At the clock edge: pop 2 or 1 halfwords, and `haddr` += 4 or 2.
- On no hit: `mem_ready` = 0 and `mem_rdata` = 0.
- Redirect: `mem_valid` is 1 and `mem_addr` ≠ `haddr`.
  - Not a hit. At the edge: `count` = 0, `rptr` = `wptr`, `haddr` = `mem_addr`, `faddr` = `mem_addr` & ~3.
  - `skip` = `mem_addr[1]`.
  - If `pend` is set and `imem_out.mem_ready` = 0, set `drop` = 1.
- Fence: `mem_fence` is 1.
  - Not a hit. Flush exactly as for a redirect to `mem_addr`.
  - Drive `imem_in.mem_fence` = 1 for that cycle.
  - Clear `pend` and set `drop` if a read is outstanding.
- Issue: when `pend` = 0 and `count` ≤ depth−2 (after this cycle's pop), assert `imem_in.mem_valid` with `faddr` from the next cycle. Set `pend`.
- Request hold: `imem_in.mem_valid` and `mem_addr` stay stable until `imem_out.mem_ready`.
- Response with `drop` = 1: discard the word, clear `drop` and `pend`. The next request uses the updated `faddr`.
- Response with `drop` = 0:
  - Write the low halfword unless `skip` is set, then the high halfword.
  - `count` += 2, or += 1 when `skip` was set.
  - `faddr` += 4, clear `skip` and `pend`.
- Same-cycle pop and push: `count` = `count` − pop + push. No overflow is possible given the issue rule.
- `faddr` wraps modulo 2^32. The pointers wrap modulo depth.

## Timing
- Reset values: `fetchbuffer_out.mem_ready` = 0, `mem_rdata` = 0, all `imem_in` fields 0.
- Reset internal state: `count` = 0, `pend` = `drop` = `skip` = 0, `haddr` = `faddr` = 0.
- Hit response is combinational in the same cycle as the request, and depends only on registered state.
- There is no bypass from `imem_out` to `fetchbuffer_out`. Data written at edge E is servable from cycle E+1.
- Redirect at cycle T with memory latency L (ready L cycles after request):
  - Request issued at T+1, or after the dropped response arrives.
  - Data written at T+1+L; first hit at T+2+L.
- Streaming: with L = 1, one request every 2 cycles sustains one compressed instruction per cycle once the buffer is primed.
- A 32-bit instruction at `haddr[1]` = 1 waits until both words have delivered their halfwords.
- Reset asserted mid-transaction: all state clears. A late `imem_out.mem_ready` after reset is ignored because `pend` = 0.

## Structure
- `wires`: `fetchbuffer_reg_type` and `init_fetchbuffer_reg`.
- `constants`: `fetchbuffer_depth`.
- Coding: two-process style, an `always_comb` computing `v` and an `always_ff` registering `r`.
- No sub-module. The halfword array is a register array inside the block.

## Test plan
- Reset, then request `0x0` with memory returning `0x00000013` at L = 1:
  - `imem_in` reads `0x0` at cycle 1.
  - `mem_ready` = 1 with `mem_rdata` = `0x00000013` at cycle 3.
- Words `0x4501_4581` at `0x0`: requests `0x0` then `0x2` are both hits returning `0x4581` then `0x4501` (upper 16 bits 0), in consecutive cycles.
- Redirect to `0x2`, memory `0x0` = `0x0093_xxxx`, `0x4` = `0xxxxx_0001`: a single hit at `0x2` returns `0x00010093` only after both words arrive.
- Redirect to `0x100` while a read of `0x8` is pending: the `0x8` response is dropped, the next `imem_in` address is `0x100`, and no stale data is ever returned.
- Fence with a full buffer:
  - `imem_in.mem_fence` pulses, `count` goes to 0, `mem_ready` = 0.
  - The refetch at the fence address completes.
- Stall fetch (`mem_valid` = 0) with memory always ready: at most 4 reads are issued (depth 8) and `count` saturates at 8.

Source files
------------

// File: rtl/constants.sv
// constants: build-time configuration shared by the instruction fetch path.
//   fetchbuffer_depth : prefetch buffer capacity in halfwords
//                       (power of two, at least 4)
package constants;

  localparam int fetchbuffer_depth = 8;

endpackage

// File: rtl/wires.sv
// wires: bus and register types for the instruction fetch path.
//   mem_in_type          : request to a memory-like port (valid/fence/instr/addr/wdata/wstrb)
//   mem_out_type         : response from a memory-like port (ready/rdata)
//   fetchbuffer_reg_type : complete registered state of the fetchbuffer
//   init_fetchbuffer_reg : reset value of that state
package wires;

  import constants::*;

  localparam int fb_ptr_w = $clog2(fetchbuffer_depth);
  localparam int fb_cnt_w = fb_ptr_w + 1;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef struct packed {
    logic [fetchbuffer_depth-1:0][15:0] hbuf;   // circular halfword store
    logic [fb_ptr_w-1:0]                rptr;   // oldest buffered halfword
    logic [fb_ptr_w-1:0]                wptr;   // next free slot
    logic [fb_cnt_w-1:0]                count;  // halfwords held (0..depth)
    logic [31:0]                        haddr;  // fetch address of hbuf[rptr]
    logic [31:0]                        faddr;  // next word to read from memory
    logic [31:0]                        iaddr;  // address of the outstanding read
    logic                               pend;   // a read is outstanding
    logic                               drop;   // outstanding read is stale
    logic                               skip;   // discard low half of next word
  } fetchbuffer_reg_type;

  localparam fetchbuffer_reg_type init_fetchbuffer_reg = '{default: '0};

endpackage

// File: rtl/fetchbuffer.sv
// fetchbuffer: instruction prefetch buffer between the fetch stage and
// instruction memory. Word-aligned reads (one outstanding) fill a circular
// halfword buffer; halfword-aligned 16/32-bit fetches are answered
// combinationally from registered state.
//   rst             in  synchronous reset, active-low
//   clk             in  clock, rising edge
//   fetchbuffer_in  in  fetch request (mem_valid, mem_fence, mem_addr)
//   fetchbuffer_out out instruction response (mem_ready, mem_rdata)
//   imem_out        in  memory response (1-cycle mem_ready pulse + word)
//   imem_in         out memory read request, held until mem_ready
module fetchbuffer
  import constants::*;
  import wires::*;
(
  input  logic        rst,
  input  logic        clk,
  input  mem_in_type  fetchbuffer_in,
  output mem_out_type fetchbuffer_out,
  input  mem_out_type imem_out,
  output mem_in_type  imem_in
);

  fetchbuffer_reg_type r;
  fetchbuffer_reg_type v;

  logic [fb_ptr_w-1:0] rptr_nx;
  logic [15:0]         lo_hw;
  logic [15:0]         hi_hw;
  logic                is32;
  logic                hit;
  logic                flush;
  logic                resp;
  logic [1:0]          pop;
  logic [1:0]          push;

  // Write-data fields and the instr hint of the request are meaningless here.
  logic unused_in;
  assign unused_in = ^{fetchbuffer_in.mem_instr, fetchbuffer_in.mem_wdata,
                       fetchbuffer_in.mem_wstrb};

  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves one
    // unassigned, which would otherwise infer a latch.
    v       = r;
    push    = 2'd0;
    rptr_nx = r.rptr + 1'b1;
    lo_hw   = r.hbuf[r.rptr];
    hi_hw   = r.hbuf[rptr_nx];
    is32    = (lo_hw[1:0] == 2'b11);

    // Fence and redirect both flush; a flushing cycle never hits.
    flush = rst & (fetchbuffer_in.mem_fence |
                   (fetchbuffer_in.mem_valid & (fetchbuffer_in.mem_addr != r.haddr)));
    hit   = rst & fetchbuffer_in.mem_valid & ~fetchbuffer_in.mem_fence &
            (fetchbuffer_in.mem_addr == r.haddr) &
            (is32 ? (r.count >= fb_cnt_w'(2)) : (r.count >= fb_cnt_w'(1)));
    pop   = hit ? (is32 ? 2'd2 : 2'd1) : 2'd0;

    // A response is only meaningful while a read is ours; a stale one after
    // a fence (pend cleared, drop set) still has to be consumed.
    resp = imem_out.mem_ready & (r.pend | r.drop);

    fetchbuffer_out.mem_ready = hit;
    fetchbuffer_out.mem_rdata = !hit ? 32'h0 :
                                is32 ? {hi_hw, lo_hw} : {16'h0, lo_hw};

    if (flush) begin
      v.count = '0;
      v.rptr  = r.wptr;
      v.haddr = fetchbuffer_in.mem_addr;
      v.faddr = {fetchbuffer_in.mem_addr[31:2], 2'b00};
      v.skip  = fetchbuffer_in.mem_addr[1];
      // A word arriving in the flush cycle belongs to the old stream.
      if (resp) begin
        v.pend = 1'b0;
        v.drop = 1'b0;
      end else if (r.pend) begin
        v.drop = 1'b1;
      end
      if (fetchbuffer_in.mem_fence) v.pend = 1'b0;
    end else begin
      v.rptr  = r.rptr + fb_ptr_w'(pop);
      v.haddr = r.haddr + 32'({pop, 1'b0});
      if (resp) begin
        v.pend = 1'b0;
        v.drop = 1'b0;
        if (!r.drop) begin
          if (!r.skip) begin
            v.hbuf[v.wptr] = imem_out.mem_rdata[15:0];
            v.wptr         = v.wptr + 1'b1;
          end
          v.hbuf[v.wptr] = imem_out.mem_rdata[31:16];
          v.wptr         = v.wptr + 1'b1;
          push           = r.skip ? 2'd1 : 2'd2;
          v.faddr        = r.faddr + 32'd4;
          v.skip         = 1'b0;
        end
      end
      v.count = r.count - fb_cnt_w'(pop) + fb_cnt_w'(push);
    end

    // Checking the post-push count leaves room for the next full word, so
    // the buffer cannot overflow. A stale read must drain before reissue.
    if (!v.pend && !v.drop && (v.count <= fb_cnt_w'(fetchbuffer_depth - 2))) begin
      v.pend  = 1'b1;
      v.iaddr = v.faddr;
    end

    // Constant request fields are gated by rst so the port reads all-zero
    // while reset is held.
    imem_in.mem_valid = r.pend;
    imem_in.mem_addr  = r.iaddr;
    imem_in.mem_fence = rst & fetchbuffer_in.mem_fence;
    imem_in.mem_instr = rst;
    imem_in.mem_wdata = 32'h0;
    imem_in.mem_wstrb = 4'h0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples this cycle's v together.
    if (!rst) r <= init_fetchbuffer_reg;
    else      r <= v;
  end

endmodule

// File: tb/tb_fetchbuffer.sv
// tb_fetchbuffer: directed scoreboard bench for fetchbuffer. Stimulus pushes
// the expected instruction word when it issues a fetch; a monitor pops and
// compares whenever the DUT raises mem_ready. A behavioural memory with
// programmable latency logs every read it accepts.
module tb_fetchbuffer;

  import constants::*;
  import wires::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  mem_in_type  fin;
  mem_out_type fout;
  mem_out_type imem_out;
  mem_in_type  imem_in;

  fetchbuffer dut (
    .rst            (rst),
    .clk            (clk),
    .fetchbuffer_in (fin),
    .fetchbuffer_out(fout),
    .imem_out       (imem_out),
    .imem_in        (imem_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sb[$];
  int          resp_cnt = 0;
  int          resp_cyc = 0;

  logic [31:0] mem_w[logic [31:0]];
  int          lat = 1;
  logic [31:0] req_addr[$];
  int          req_cyc[$];
  int          busy_cnt = 0;
  logic [31:0] busy_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_req(input string name, input int idx, input logic [31:0] exp);
    if (idx < 0 || idx >= req_addr.size()) begin
      total++;
      bad++;
      $display("FAIL %s: got no request #%0d, expected address %h", name, idx, exp);
    end else begin
      check(name, req_addr[idx], exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_w.exists(a) ? mem_w[a] : 32'hffff_ffff;
  endfunction

  function automatic logic [15:0] hw(input int i);
    return 16'h1001 + 16'(i << 4);
  endfunction

  // Memory: accepts a read when idle, answers lat cycles later with a pulse.
  initial begin
    imem_out = '0;
    forever begin
      @(negedge clk);
      imem_out.mem_ready = 1'b0;
      imem_out.mem_rdata = 32'h0;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          imem_out.mem_ready = 1'b1;
          imem_out.mem_rdata = rd(busy_addr);
        end
      end else if (imem_in.mem_valid) begin
        busy_addr = imem_in.mem_addr;
        busy_cnt  = lat;
        req_addr.push_back(imem_in.mem_addr);
        req_cyc.push_back(cyc);
      end
    end
  end

  // Monitor: every presented instruction must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (fout.mem_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got %h expected none", fout.mem_rdata);
        end else begin
          check("fetch_data", fout.mem_rdata, sb.pop_front());
        end
        resp_cnt++;
        resp_cyc = cyc;
      end
    end
  end

  task automatic do_reset(input int l);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fin = '0;
    repeat (6) @(posedge clk);
    #1;
    lat = l;
    req_addr.delete();
    req_cyc.delete();
    rst  = 1'b1;
    base = cyc;
  endtask

  task automatic idle();
    fin.mem_valid = 1'b0;
    fin.mem_fence = 1'b0;
  endtask

  // Holds the request until the DUT takes it; rc is the response cycle
  // relative to reset release, or -1 on timeout.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp,
                       input int budget, output int rc);
    int  n0;
    bit  ok;
    sb.push_back(exp);
    fin.mem_valid = 1'b1;
    fin.mem_fence = 1'b0;
    fin.mem_addr  = a;
    n0 = resp_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (resp_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: got no response for %h, expected %h", a, exp);
      void'(sb.pop_back());
      rc = -1;
    end else begin
      rc = resp_cyc - base;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, rc1, rc2, n, i8, first;
    bit seen;
    fin = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(fout.mem_ready), 32'd0);
    check("rst_rdata", fout.mem_rdata, 32'd0);
    check("rst_imem_in_nonzero", 32'(imem_in != '0), 32'd0);

    // First fetch after reset, L = 1
    mem_w.delete();
    mem_w[32'h0] = 32'h0000_0013;
    do_reset(1);
    fetch(32'h0, 32'h0000_0013, 20, rc);
    idle();
    check("t1_resp_cycle", 32'(rc), 32'd3);
    check_req("t1_req_addr", 0, 32'h0);
    if (req_cyc.size() > 0) check("t1_req_cycle", 32'(req_cyc[0] - base), 32'd1);
    else check_req("t1_req_cycle", 0, 32'h0);

    // Two compressed instructions from one word, back to back
    mem_w.delete();
    mem_w[32'h0] = 32'h4501_4581;
    do_reset(1);
    fetch(32'h0, 32'h0000_4581, 20, rc1);
    fetch(32'h2, 32'h0000_4501, 20, rc2);
    idle();
    check("t2_consecutive", 32'(rc2 - rc1), 32'd1);

    // Misaligned 32-bit instruction spanning two words
    mem_w.delete();
    mem_w[32'h0] = 32'h0093_1234;
    mem_w[32'h4] = 32'h5678_0001;
    do_reset(1);
    fetch(32'h2, 32'h0001_0093, 30, rc);
    idle();
    check("t3_resp_cycle", 32'(rc), 32'd5);
    check_req("t3_req0", 0, 32'h0);
    check_req("t3_req1", 1, 32'h4);

    // Redirect while the read of 0x8 is outstanding, L = 3
    mem_w.delete();
    mem_w[32'h0]   = 32'h0001_0001;
    mem_w[32'h4]   = 32'h0001_0001;
    mem_w[32'h8]   = 32'h5555_5555;
    mem_w[32'h100] = 32'h1234_0001;
    do_reset(3);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      foreach (req_addr[k]) if (req_addr[k] == 32'h8) seen = 1'b1;
    end
    #1;
    check("t4_saw_read_8", 32'(seen), 32'd1);
    fetch(32'h100, 32'h0000_0001, 40, rc);
    fetch(32'h102, 32'h0000_1234, 20, rc);
    idle();
    i8 = -1;
    foreach (req_addr[k]) if (req_addr[k] == 32'h8 && i8 < 0) i8 = k;
    check_req("t4_after_drop", i8 + 1, 32'h100);

    // Stalled fetch fills the buffer, then a fence flushes it
    mem_w.delete();
    for (int k = 0; k < 4; k++) mem_w[32'(k * 4)] = 32'h0005_0001;
    do_reset(1);
    repeat (24) @(posedge clk);
    #1;
    check("t5_reads_when_full", 32'(req_addr.size()), 32'd4);
    mem_w[32'h0] = 32'h0009_0009;
    fin.mem_valid = 1'b1;
    fin.mem_addr  = 32'h0;
    fin.mem_fence = 1'b1;
    @(negedge clk);
    check("t5_fence_pulse", 32'(imem_in.mem_fence), 32'd1);
    check("t5_fence_ready", 32'(fout.mem_ready), 32'd0);
    @(posedge clk);
    #1;
    fin.mem_fence = 1'b0;
    n = req_addr.size();
    fetch(32'h0, 32'h0000_0009, 20, rc);
    idle();
    check_req("t5_refetch_addr", n, 32'h0);

    // Streaming compressed instructions from a primed buffer, L = 1
    mem_w.delete();
    for (int k = 0; k < 8; k++) mem_w[32'(k * 4)] = {hw(2 * k + 1), hw(2 * k)};
    do_reset(1);
    repeat (12) @(posedge clk);
    #1;
    first = 0;
    for (int i = 0; i < 16; i++) begin
      fetch(32'(2 * i), {16'h0, hw(i)}, 10, rc);
      if (i == 0) first = rc;
    end
    idle();
    check("t6_stream_span", 32'(rc - first), 32'd15);

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
